// File: rtl/ps2_pkg.sv
// Shared PS/2 link definitions: frame layout,
// well-known scan codes and transmitter FSM states.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } ps2_state_e;

  // Wire order, LSB goes out first.
  function automatic logic [FRAME_BITS-1:0]
    ps2_frame(input logic [7:0] code);
    return {STOP_BIT, ~^code, code, START_BIT};
  endfunction

endpackage

// File: rtl/ps2_keyboard_tx_if.sv
// Scan-code write port of the PS/2 keyboard
// transmitter: push side plus status back.
interface ps2_keyboard_tx_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  overflow,
    input  busy
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output overflow,
    output busy
  );

endinterface

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO with registered full and
// empty; pushes while full are dropped.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Pointer/count update and next-cycle flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok)
             - CW'(pop_ok);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; empty guards reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: queues scan codes
// and sends each as an 11-bit frame.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  ps2_keyboard_tx_if.slave   wr,
  output logic               ps2_clk,
  output logic               ps2_data
);

  localparam int PMAX =
    (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int PW =
    (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] HALF_END =
    PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GAP_END =
    PW'(GAP_CYCLES - 1);
  localparam logic [3:0] LAST_BIT =
    4'(FRAME_BITS - 1);

  ps2_state_e            state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  clk_q, clk_d;
  logic                  data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  pop;
  logic [7:0]            fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr.wr_en),
    .din   (wr.wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: bit timing, shifter, line levels.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_d     = clk_q;
    data_d    = data_q;
    pop       = 1'b0;
    ovf_d     = wr.wr_en & fifo_full;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = ps2_frame(fifo_dout);
          data_d    = START_BIT;
          clk_d     = 1'b1;
          bit_cnt_d = '0;
          phase_d   = '0;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (phase_q == HALF_END) begin
          clk_d   = 1'b0;
          phase_d = '0;
          state_d = LOW;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LOW: begin
        if (phase_q == HALF_END) begin
          clk_d   = 1'b1;
          phase_d = '0;
          if (bit_cnt_q < LAST_BIT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            data_d    = shift_q[1];
            state_d   = HIGH;
          end else begin
            data_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      GAP: begin
        if (phase_q == GAP_END) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_q     <= clk_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ps2_clk     = clk_q;
  assign ps2_data    = data_q;
  assign wr.full     = fifo_full;
  assign wr.overflow = ovf_q;
  assign wr.busy     = (state_q != IDLE)
                     | ~fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: stimulus queues the
// expected frames, a line monitor decodes and compares.
module tb_ps2_keyboard_tx;

  localparam int CLK_DIV = 8;
  localparam int GAPC    = 16;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk;
  logic ps2_data;

  ps2_keyboard_tx_if bus();

  ps2_keyboard_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .wr       (bus.slave),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_bits[$];
  logic [7:0] exp_bytes[$];
  int falls = 0;
  int gaps_seen = 0;
  bit gap_chk = 1'b0;

  logic m_pclk = 1'b1;
  logic m_pdata = 1'b1;
  int nb = 0;
  logic [10:0] fr;
  int hi_run = 0;
  bit armed = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Receiver model on the PS/2 lines.
  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 0;
      hi_run = 0;
      armed = 1'b0;
      m_pclk = 1'b1;
      m_pdata = 1'b1;
    end else begin
      if (!gap_chk) armed = 1'b0;
      if (armed && ps2_clk && m_pdata && !ps2_data) begin
        check("gap_len", hi_run, GAPC + 1);
        gaps_seen++;
        armed = 1'b0;
      end
      hi_run = (ps2_clk && ps2_data) ? hi_run + 1 : 0;
      if (m_pclk && !ps2_clk) begin
        falls++;
        if (exp_bits.size() == 0) begin
          check("unexpected_fall", 1, 0);
        end else begin
          check($sformatf("bit%0d", nb), ps2_data,
                exp_bits.pop_front());
        end
        fr[nb] = ps2_data;
        nb++;
        if (nb == 11) begin
          nb = 0;
          if (exp_bytes.size() == 0)
            check("unexpected_byte", 1, 0);
          else
            check("rx_byte", fr[8:1],
                  exp_bytes.pop_front());
          if (gap_chk) armed = 1'b1;
        end
      end
      m_pclk = ps2_clk;
      m_pdata = ps2_data;
    end
  end

  // Called at a negedge; returns at the next negedge.
  task automatic push(input logic [7:0] d,
                      input bit par,
                      input bit keep);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (keep) begin
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        exp_bits.push_back(d[i]);
      exp_bits.push_back(par);
      exp_bits.push_back(1'b1);
      exp_bytes.push_back(d);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_bits.size() != 0 || bus.busy)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done",
          {31'd0, (exp_bits.size() == 0 && !bus.busy)},
          1);
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] par_code [3] = '{8'h00, 8'hFF, 8'h01};
  bit         par_bit  [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] ovf_code [8] = '{8'h15, 8'h2A, 8'h33,
    8'h80, 8'h7F, 8'hE0, 8'h12, 8'h5A};
  bit         ovf_par  [8] = '{1'b0, 1'b0, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    int g0;
    int f0;
    int n;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk", ps2_clk, 1);
    check("rst_data", ps2_data, 1);
    check("rst_full", bus.full, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!ps2_clk || !ps2_data || bus.busy) bad++;
    end
    check("idle_1000", bad, 0);

    push(8'h1C, 1'b0, 1'b1);
    k = 0;
    check("busy_after_push", bus.busy, 1);
    while (ps2_clk && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("first_fall_cycles", k, 9);
    while (k < 176) begin
      @(negedge clk);
      k++;
    end
    check("stop_low_176", ps2_clk, 0);
    @(negedge clk);
    check("lines_high_177", {ps2_clk, ps2_data}, 2'b11);
    drain(400);

    g0 = gaps_seen;
    gap_chk = 1'b1;
    push(8'hF0, 1'b1, 1'b1);
    push(8'h1C, 1'b0, 1'b1);
    drain(600);
    gap_chk = 1'b0;
    check("gaps_b2b", gaps_seen - g0, 1);

    for (int i = 0; i < 3; i++) begin
      push(par_code[i], par_bit[i], 1'b1);
      drain(400);
    end

    push(8'h1C, 1'b0, 1'b1);
    n = 0;
    while (ps2_clk && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ovf_frame_started", ps2_clk, 0);
    g0 = gaps_seen;
    gap_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(ovf_code[i], ovf_par[i], 1'b1);
      if (i == 6) check("full_after_7", bus.full, 0);
    end
    check("full_after_8", bus.full, 1);
    check("no_ovf_yet", bus.overflow, 0);
    push(8'hAA, 1'b0, 1'b0);
    check("ovf_pulse", bus.overflow, 1);
    check("full_still", bus.full, 1);
    @(negedge clk);
    check("ovf_one_cycle", bus.overflow, 0);
    drain(3000);
    gap_chk = 1'b0;
    check("gaps_burst", gaps_seen - g0, 8);

    push(8'h15, 1'b0, 1'b1);
    push(8'h33, 1'b1, 1'b1);
    f0 = falls;
    n = 0;
    while (falls < f0 + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit4", falls - f0, 5);
    check("bit4_low_phase", {ps2_clk, ps2_data}, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk", ps2_clk, 1);
    check("arst_data", ps2_data, 1);
    check("arst_busy", bus.busy, 0);
    check("arst_full", bus.full, 0);
    exp_bits.delete();
    exp_bytes.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = falls;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (!ps2_clk || !ps2_data || bus.busy) bad++;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_falls", falls - f0, 0);

    check("exp_bits_empty", exp_bits.size(), 0);
    check("exp_bytes_empty", exp_bytes.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
- PS/2 device-side transmitter: the keyboard end of the link our scan-code receiver consumes.
- Accepts 8-bit scan codes (make codes, 8'hF0 break prefix, etc.) into a small FIFO.
- Serialises each code as a standard 11-bit PS/2 frame on ps2_clk/ps2_data.
- Used as the keyboard model in NPC simulation and as a loopback source on FPGA.

Parameters:
CLK_DIV, 8, system clocks per PS/2 clock half-period (>=2)
GAP_CYCLES, 16, idle system clocks between frames, ps2_clk/ps2_data held high (>=1)
FIFO_DEPTH, 8, scan-code FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low; 0 = reset
wr_en  input  1  push wr_data this cycle
wr_data  input  8  scan code to send
full  output  1  FIFO full; push this cycle is dropped
overflow  output  1  one-cycle pulse, registered the cycle after a dropped push
busy  output  1  high when state != IDLE or FIFO non-empty
ps2_clk  output  1  PS/2 clock, idle high
ps2_data  output  1  PS/2 data, idle high

Behaviour:
- Reset (async assert, sync release): ps2_clk=1, ps2_data=1, full=0, overflow=0, busy=0, FIFO emptied, state=IDLE, counters cleared. Reset mid-frame truncates the frame; no resume.
- Frame, LSB first: start 0, data[0..7], odd parity (~^data), stop 1. FRAME_BITS=11.
- Bit timing:
  - Each bit occupies 2*CLK_DIV cycles: ps2_clk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - ps2_data changes only on the edge that raises ps2_clk (or leaves IDLE), so data is stable across every falling ps2_clk edge.
  - Frame = 22*CLK_DIV cycles.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load shift register {1, parity, data, 0}, drive ps2_data=0 (start) -> HIGH.
  - HIGH: after CLK_DIV cycles, ps2_clk<=0 -> LOW.
  - LOW: after CLK_DIV cycles, ps2_clk<=1. If bit counter < 10, shift, drive next bit -> HIGH. Otherwise ps2_data<=1 -> GAP.
  - GAP: both lines high for GAP_CYCLES cycles -> IDLE.
- Latency: wr_en at edge N into an empty FIFO with state IDLE -> pop and start bit at edge N+1. First ps2_clk fall at edge N+1+CLK_DIV.
- Back-to-back codes: next start bit GAP_CYCLES+1 cycles after the stop bit's rising ps2_clk edge.
- FIFO:
  - Synchronous, registered full/empty.
  - full is evaluated before any same-cycle pop: push while full is dropped even if IDLE pops that cycle.
  - Push into empty while IDLE: the byte is not visible until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count width clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop when not full: both take effect, count unchanged.
- Bit counter 4 bits (0..10). Phase counter clog2(max(CLK_DIV,GAP_CYCLES)) bits, reloaded on every state change.
- ps2_clk and ps2_data come straight from flops (glitch-free).

Decomposition:
- Shared package ps2_pkg: FRAME_BITS=11, START_BIT=0, STOP_BIT=1, BREAK_CODE=8'hF0, EXT_CODE=8'hE0, FSM state encoding (IDLE, HIGH, LOW, GAP). The receiver side reuses the same package.
- One sub-module: ps2_tx_fifo (parameterised sync FIFO; ports clk, reset, push, din, pop, dout, full, empty).
- FSM, shifter and counters stay in ps2_keyboard_tx.

Test Plan:
- Single code 8'h1C, CLK_DIV=8 -> eleven values sampled on ps2_clk falling edges: 0,0,0,1,1,1,0,0,0,0,1 (parity 0). First fall 9 cycles after push edge. Lines high after 176 cycles.
- Codes 8'hF0 then 8'h1C pushed consecutively -> frames 0,0,0,0,0,1,1,1,1,1,1 then 0x1C frame. Exactly GAP_CYCLES+1 cycles of both-high between them. Receiver model decodes F0,1C.
- Parity corners: 8'h00 -> parity 1; 8'hFF -> parity 1; 8'h01 -> parity 0. Stop always 1, start always 0.
- Overflow, FIFO_DEPTH=8: during an active frame push 9 bytes on consecutive cycles -> full rises after the 8th. 9th dropped, overflow pulses one cycle. Subsequently exactly 8 frames are sent, in order.
- Reset asserted mid-frame (during bit 4 LOW phase) -> ps2_clk and ps2_data go 1 immediately (async). FIFO empty, busy=0. After release, no further frame until a new push.
- Idle check: no pushes for 1000 cycles after reset -> ps2_clk=1, ps2_data=1, busy=0 throughout.
